// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states, lane width.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned LANE_W = 8;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load extract/extend and store replicate/mask.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] wrep,
    output logic [3:0]  wmask
);

    logic [LANE_W-1:0]   byte_sel;
    logic [2*LANE_W-1:0] half_sel;

    // Half accesses use offset[1] only, so a misaligned half is force-aligned.
    assign byte_sel = rword[{offset, 3'b000} +: LANE_W];
    assign half_sel = offset[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ldata = '0;
        wrep  = '0;
        wmask = '0;
        case (size)
            SZ_BYTE: begin
                ldata = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                wrep  = {4{wdata[7:0]}};
                wmask = 4'b0001 << offset;
            end
            SZ_HALF: begin
                ldata = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                wrep  = {2{wdata[15:0]}};
                wmask = offset[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                ldata = rword;
                wrep  = wdata;
                wmask = '1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word access, configurable latency, range/size errors.
// Define DMEM_ALIGN_CHECK_EN to report misaligned half/word accesses as errors.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              err_o
);

    localparam int unsigned IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               accept, complete;

    logic               l_we, l_uns;
    logic [1:0]         l_size;
    logic [ADDR_W-1:0]  l_addr;
    logic [31:0]        l_wdata;

    logic               op_we, op_uns;
    logic [1:0]         op_size;
    logic [ADDR_W-1:0]  op_addr;
    logic [31:0]        op_wdata;

    logic [ADDR_W-3:0]  word_idx;
    logic [IDX_W-1:0]   mem_idx;
    logic               range_err, size_err, align_err, op_err;
    logic [31:0]        rword, ldata, wrep;
    logic [3:0]         wmask;

    logic [31:0]        mem [DEPTH];

    // Single-cycle build completes on the accept edge, so it works from the live inputs.
    assign op_we    = (LATENCY == 1) ? we_i       : l_we;
    assign op_uns   = (LATENCY == 1) ? unsigned_i : l_uns;
    assign op_size  = (LATENCY == 1) ? size_i     : l_size;
    assign op_addr  = (LATENCY == 1) ? addr_i     : l_addr;
    assign op_wdata = (LATENCY == 1) ? wdata_i    : l_wdata;

    assign word_idx  = op_addr[ADDR_W-1:2];
    assign mem_idx   = op_addr[IDX_W+1:2];
    assign range_err = word_idx >= (ADDR_W-2)'(DEPTH);
    assign size_err  = (op_size == 2'b11);
`ifdef DMEM_ALIGN_CHECK_EN
    assign align_err = ((op_size == SZ_HALF) && op_addr[0]) ||
                       ((op_size == SZ_WORD) && (op_addr[1:0] != 2'b00));
`else
    assign align_err = 1'b0;
`endif
    assign op_err    = range_err || size_err || align_err;
    assign rword     = mem[mem_idx];
    assign busy_o    = (state == ST_BUSY);

    dmem_lane_align u_lane_align (
        .rword  (rword),
        .offset (op_addr[1:0]),
        .size   (op_size),
        .uns    (op_uns),
        .wdata  (op_wdata),
        .ldata  (ldata),
        .wrep   (wrep),
        .wmask  (wmask)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_i) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        complete = 1'b1;
                    end else begin
                        state_nxt = ST_BUSY;
                        cnt_nxt   = CNT_W'(LATENCY - 32'd2);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_o <= complete;
            if (complete) begin
                err_o <= op_err;
                if (!op_we) begin
                    rdata_o <= op_err ? '0 : ldata;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            l_we    <= we_i;
            l_uns   <= unsigned_i;
            l_size  <= size_i;
            l_addr  <= addr_i;
            l_wdata <= wdata_i;
        end
    end

    // Reset gates the commit so an aborted store never reaches the array.
    always_ff @(posedge clk_i) begin
        if (!rst_i && complete && op_we && !op_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[mem_idx][i*LANE_W +: LANE_W] <= wrep[i*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: LATENCY=1 and LATENCY=3 instances run the same access stream against a model.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, req3;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        busy1, done1, err1;
    logic [31:0] rdata1;
    logic        busy3, done3, err3;
    logic [31:0] rdata3;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] mdl [32];
    logic [31:0] exp_rdata;
    logic        exp_err;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(32), .ADDR_W(32), .LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .size_i(size),
        .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy1), .done_o(done1), .rdata_o(rdata1), .err_o(err1)
    );

    dmem_ctrl #(.DEPTH(32), .ADDR_W(32), .LATENCY(3)) u_dut_l3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .we_i(we), .size_i(size),
        .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy3), .done_o(done3), .rdata_o(rdata3), .err_o(err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour computed from the access rules with shifts and masks.
    task automatic model(input logic t_we, input logic [1:0] t_size, input logic t_uns,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata);
        int unsigned idx, off, sh;
        logic [31:0] w, v;
        logic        e;
        idx = t_addr >> 2;
        off = t_addr % 4;
        e = (idx >= 32) || (t_size == 2'd3);
`ifdef DMEM_ALIGN_CHECK_EN
        e = e || (t_size == 2'd1 && (off % 2) != 0) || (t_size == 2'd2 && off != 0);
`endif
        exp_err = e;
        if (e) begin
            if (!t_we) exp_rdata = 32'h0;
            return;
        end
        w = mdl[idx];
        if (!t_we) begin
            case (t_size)
                2'd0: begin
                    v = (w >> (8 * off)) & 32'hFF;
                    if (!t_uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
                end
                2'd1: begin
                    v = (w >> (16 * (off / 2))) & 32'hFFFF;
                    if (!t_uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
                end
                default: v = w;
            endcase
            exp_rdata = v;
        end else begin
            case (t_size)
                2'd0: begin
                    sh = 8 * off;
                    mdl[idx] = (w & ~(32'hFF << sh)) | ((t_wdata & 32'hFF) << sh);
                end
                2'd1: begin
                    sh = 16 * (off / 2);
                    mdl[idx] = (w & ~(32'hFFFF << sh)) | ((t_wdata & 32'hFFFF) << sh);
                end
                default: mdl[idx] = t_wdata;
            endcase
        end
    endtask

    task automatic scramble();
        req3  = 1'($urandom_range(0, 1));
        we    = 1'($urandom_range(0, 1));
        size  = 2'($urandom_range(0, 3));
        uns   = 1'($urandom_range(0, 1));
        addr  = $urandom;
        wdata = $urandom;
    endtask

    // Called at a negedge; the next call may follow immediately, landing in the done cycle.
    task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_uns,
                           input logic [31:0] t_addr, input logic [31:0] t_wdata);
        we = t_we; size = t_size; uns = t_uns; addr = t_addr; wdata = t_wdata;
        req1 = 1'b1; req3 = 1'b1;
        model(t_we, t_size, t_uns, t_addr, t_wdata);
        @(posedge clk); @(negedge clk);
        check("l1_done",   32'(done1), 32'd1);
        check("l1_busy",   32'(busy1), 32'd0);
        check("l1_err",    32'(err1),  32'(exp_err));
        check("l1_rdata",  rdata1,     exp_rdata);
        check("l3_busy_a", 32'(busy3), 32'd1);
        check("l3_done_a", 32'(done3), 32'd0);
        req1 = 1'b0;
        scramble();
        @(posedge clk); @(negedge clk);
        check("l3_busy_b", 32'(busy3), 32'd1);
        check("l3_done_b", 32'(done3), 32'd0);
        check("l1_idle",   32'(done1), 32'd0);
        scramble();
        @(posedge clk); @(negedge clk);
        check("l3_done",   32'(done3), 32'd1);
        check("l3_busy_c", 32'(busy3), 32'd0);
        check("l3_err",    32'(err3),  32'(exp_err));
        check("l3_rdata",  rdata3,     exp_rdata);
        check("l1_busy_c", 32'(busy1), 32'd0);
        req1 = 1'b0; req3 = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_busy1",  32'(busy1), 32'd0);
        check("rst_done1",  32'(done1), 32'd0);
        check("rst_err1",   32'(err1),  32'd0);
        check("rst_rdata1", rdata1,     32'd0);
        check("rst_busy3",  32'(busy3), 32'd0);
        check("rst_done3",  32'(done3), 32'd0);
        check("rst_err3",   32'(err3),  32'd0);
        check("rst_rdata3", rdata3,     32'd0);
    endtask

    initial begin
        logic [31:0] r_addr;
        logic [1:0]  r_size;
        int unsigned sel;

        rst = 1'b1; req1 = 1'b0; req3 = 1'b0; we = 1'b0; size = 2'b00;
        uns = 1'b0; addr = '0; wdata = '0;
        exp_rdata = '0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        for (int i = 0; i < 32; i++) run_txn(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);

        run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw_deadbeef", rdata1, 32'hDEAD_BEEF);

        run_txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_7F01);
        run_txn(1'b0, 2'd0, 1'b0, 32'h22, 32'h0);
        check("lb_22", rdata3, 32'hFFFF_FFFF);
        run_txn(1'b0, 2'd0, 1'b1, 32'h22, 32'h0);
        check("lbu_22", rdata3, 32'h0000_00FF);
        run_txn(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        check("lh_22", rdata3, 32'hFFFF_80FF);
        run_txn(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
        check("lhu_20", rdata3, 32'h0000_7F01);

        run_txn(1'b1, 2'd2, 1'b0, 32'h04, 32'h1122_3344);
        run_txn(1'b1, 2'd0, 1'b0, 32'h05, 32'h0000_00AA);
        run_txn(1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
        check("sb_partial", rdata3, 32'h1122_AA44);

        run_txn(1'b1, 2'd2, 1'b0, 32'h80, 32'h5555_5555);
        check("st_range_err", 32'(err3), 32'd1);
        run_txn(1'b0, 2'd3, 1'b0, 32'h04, 32'h0);
        check("size11_err", 32'(err3), 32'd1);
        check("size11_rdata", rdata3, 32'h0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
        check("err_clear", 32'(err3), 32'd0);

        run_txn(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        check("lw_misalign_err", 32'(err3), 32'd1);
`else
        check("lw_force_align", rdata3, 32'h1122_AA44);
`endif

        // Store aborted by reset while the LATENCY=3 instance is busy.
        we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h40; wdata = ~mdl[16];
        req3 = 1'b1; req1 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort_busy", 32'(busy3), 32'd1);
        req3 = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        exp_rdata = '0; exp_err = 1'b0;
        run_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0)      r_addr = $urandom_range(128, 255);
            else if (sel == 1) r_addr = $urandom;
            else               r_addr = $urandom_range(0, 127);
            sel = $urandom_range(0, 9);
            r_size = (sel == 0) ? 2'd3 : 2'(sel % 3);
            run_txn(1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)), r_addr, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
